// File: rtl/boron_pkg.sv
// Shared BORON-64/80 definitions: S-box tables, sizes, word rotation amounts,
// FSM state encoding and the forward/inverse 80-bit key schedule step.
package boron_pkg;

    localparam int NR      = 25;
    localparam int BLK_W   = 64;
    localparam int KEY_W   = 80;
    localparam int KEY_ROT = 13;

    // Nibble i of each table lives at bits [4*i +: 4]
    localparam logic [63:0] SBOX     = 64'h6358F02DAC971B4E;
    localparam logic [63:0] SBOX_INV = 64'hB086275C4FD1E93A;

    // Left-rotation amount applied to 16-bit word i (word 0 = bits 15:0)
    localparam int ROT [4] = '{1, 4, 7, 9};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_WHITEN,
        ST_ROUND,
        ST_DONE
    } state_e;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        return SBOX[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] f_sbox_inv(input logic [3:0] x);
        return SBOX_INV[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] f_rotr16(input logic [15:0] x, input int n);
        return 16'({x, x} >> n);
    endfunction

    // K <<< 13; S on the low nibble; round constant into K[63:59]
    function automatic logic [KEY_W-1:0] f_key_step(input logic [KEY_W-1:0] k,
                                                    input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t        = {k[KEY_W-KEY_ROT-1:0], k[KEY_W-1:KEY_W-KEY_ROT]};
        t[3:0]   = f_sbox(t[3:0]);
        t[63:59] = t[63:59] ^ rc;
        return t;
    endfunction

    // Exact inverse of f_key_step for the same rc
    function automatic logic [KEY_W-1:0] f_key_step_inv(input logic [KEY_W-1:0] k,
                                                        input logic [4:0] rc);
        logic [KEY_W-1:0] t;
        t        = k;
        t[63:59] = t[63:59] ^ rc;
        t[3:0]   = f_sbox_inv(t[3:0]);
        return {t[KEY_ROT-1:0], t[KEY_W-1:KEY_ROT]};
    endfunction

endpackage

// File: rtl/boron_dec_if.sv
// Request/response bundle of the BORON decryption core.
interface boron_dec_if;
    import boron_pkg::*;

    logic             start;
    logic [BLK_W-1:0] cipher_text;
    logic [KEY_W-1:0] master_key;
    logic             busy;
    logic             done;
    logic [BLK_W-1:0] plain_text;

    modport master (output start, cipher_text, master_key,
                    input  busy, done, plain_text);
    modport slave  (input  start, cipher_text, master_key,
                    output busy, done, plain_text);
endinterface

// File: rtl/boron_dec_round.sv
// Combinational inverse BORON round: undo XOR-op, word rotation, byte
// shuffle and S-box layer, then add the round key.
module boron_dec_round
    import boron_pkg::*;
(
    input  logic [BLK_W-1:0] state_in,
    input  logic [BLK_W-1:0] rk,
    output logic [BLK_W-1:0] state_out
);

    logic [15:0]      y [4];
    logic [15:0]      w [4];
    logic [BLK_W-1:0] s;

    // Peel the encryption layers off in reverse order
    always_comb begin
        for (int i = 0; i < 4; i++) y[i] = state_in[16*i +: 16];
        // Forward op was: w0^=w1; w2^=w3; w3^=w0 (sequential)
        w[3] = y[3] ^ y[0];
        w[1] = y[1];
        w[0] = y[0] ^ y[1];
        w[2] = y[2] ^ w[3];
        for (int i = 0; i < 4; i++) w[i] = f_rotr16(w[i], ROT[i]);
        for (int i = 0; i < 4; i++) w[i] = {w[i][7:0], w[i][15:8]};
        for (int i = 0; i < 4; i++) s[16*i +: 16] = w[i];
        for (int j = 0; j < 16; j++) s[4*j +: 4] = f_sbox_inv(s[4*j +: 4]);
        state_out = s ^ rk;
    end

endmodule

// File: rtl/boron_dec.sv
// Iterative BORON-64/80 decryption core. Runs the forward key schedule to
// reach the final round key, whitens, then unwinds NR inverse rounds.
// Optional feature macro: BORON_DEC_KEY_CACHE_EN (caches the last master key
// and its final round key so a repeated key skips key expansion).
module boron_dec
    import boron_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    boron_dec_if.slave  bus
);

    localparam logic [4:0] RC_FIRST = 5'd1;
    localparam logic [4:0] RC_LAST  = 5'(NR);

    state_e           state_q, state_d;
    logic [4:0]       rc_q, rc_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] pt_q, pt_d;
    logic             done_q, done_d;

    logic [KEY_W-1:0] key_fwd;
    logic [KEY_W-1:0] key_inv;
    logic [BLK_W-1:0] round_out;

`ifdef BORON_DEC_KEY_CACHE_EN
    // Full 80-bit final key is kept because the rounds unwind the whole register
    logic [KEY_W-1:0] ck_key_q, ck_key_d;
    logic [KEY_W-1:0] ck_final_q, ck_final_d;
    logic             ck_vld_q, ck_vld_d;
    logic             ck_hit;

    assign ck_hit = ck_vld_q && (bus.master_key == ck_key_q);
`endif

    assign key_fwd = f_key_step(key_q, rc_q);
    assign key_inv = f_key_step_inv(key_q, rc_q);

    boron_dec_round u_round (
        .state_in  (blk_q),
        .rk        (key_inv[BLK_W-1:0]),
        .state_out (round_out)
    );

    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.plain_text = pt_q;

    // Next-state, counter, key and data path control
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        key_d   = key_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
`ifdef BORON_DEC_KEY_CACHE_EN
        ck_key_d   = ck_key_q;
        ck_final_d = ck_final_q;
        ck_vld_d   = ck_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    blk_d   = bus.cipher_text;
                    key_d   = bus.master_key;
                    rc_d    = RC_FIRST;
                    state_d = ST_KEYEXP;
`ifdef BORON_DEC_KEY_CACHE_EN
                    if (ck_hit) begin
                        key_d   = ck_final_q;
                        rc_d    = RC_LAST;
                        state_d = ST_WHITEN;
                    end else begin
                        ck_key_d = bus.master_key;
                        ck_vld_d = 1'b0;
                    end
`endif
                end
            end
            ST_KEYEXP: begin
                key_d = key_fwd;
                if (rc_q == RC_LAST) begin
                    // rc stays at NR: the first inverse round undoes that step
                    state_d = ST_WHITEN;
`ifdef BORON_DEC_KEY_CACHE_EN
                    ck_final_d = key_fwd;
                    ck_vld_d   = 1'b1;
`endif
                end else begin
                    rc_d = rc_q + 5'd1;
                end
            end
            ST_WHITEN: begin
                blk_d   = blk_q ^ key_q[BLK_W-1:0];
                state_d = ST_ROUND;
            end
            ST_ROUND: begin
                key_d = key_inv;
                blk_d = round_out;
                rc_d  = rc_q - 5'd1;
                if (rc_q == RC_FIRST) state_d = ST_DONE;
            end
            ST_DONE: begin
                pt_d    = blk_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            key_q   <= '0;
            blk_q   <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
`ifdef BORON_DEC_KEY_CACHE_EN
            ck_key_q   <= '0;
            ck_final_q <= '0;
            ck_vld_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
`ifdef BORON_DEC_KEY_CACHE_EN
            ck_key_q   <= ck_key_d;
            ck_final_q <= ck_final_d;
            ck_vld_q   <= ck_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_boron_dec.sv
// Bench for boron_dec: encrypts with a behavioural BORON-64/80 model, feeds the
// ciphertext to the decryptor and expects the original plaintext back.
module tb_boron_dec;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    boron_dec_if bif();

    boron_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0] sb [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                            4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
    int wrot [4] = '{1, 4, 7, 9};

`ifdef BORON_DEC_KEY_CACHE_EN
    bit          cvld = 1'b0;
    logic [79:0] ckey = '0;
`endif

    logic [63:0] h_pt  [3];
    logic [79:0] h_key [3];
    int          h_due [3];
    int          seen_t [$];
    logic [63:0] seen_pt [$];
    logic [63:0] pt_a;
    logic [79:0] key_a;
    int          lat_a;

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [79:0] rand80();
        return 80'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] x, input int n);
        return (x << n) | (x >> (16 - n));
    endfunction

    // Reference BORON-64/80 encryption: 25 rounds then output whitening
    function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] key);
        logic [79:0] k;
        logic [63:0] s;
        logic [15:0] w [4];
        k = key;
        s = pt;
        for (int r = 1; r <= 25; r++) begin
            s = s ^ k[63:0];
            for (int i = 0; i < 16; i++) s[4*i +: 4] = sb[s[4*i +: 4]];
            for (int i = 0; i < 4; i++) begin
                w[i] = s[16*i +: 16];
                w[i] = {w[i][7:0], w[i][15:8]};
                w[i] = rotl16(w[i], wrot[i]);
            end
            w[0] = w[0] ^ w[1];
            w[2] = w[2] ^ w[3];
            w[3] = w[3] ^ w[0];
            s = {w[3], w[2], w[1], w[0]};
            k = {k[66:0], k[79:67]};
            k[3:0] = sb[k[3:0]];
            k[63:59] = k[63:59] ^ 5'(r);
        end
        return s ^ k[63:0];
    endfunction

    // Expected start-to-done latency, tracking the optional key cache
    function automatic int exp_lat(input logic [79:0] k);
`ifdef BORON_DEC_KEY_CACHE_EN
        if (cvld && k == ckey) return 27;
        ckey = k;
        cvld = 1'b1;
`endif
        return 52;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
`ifdef BORON_DEC_KEY_CACHE_EN
        cvld = 1'b0;
`endif
    endtask

    task automatic do_op(input logic [63:0] pt, input logic [79:0] key,
                         input int poke_a, input int poke_b, input string tag);
        int n;
        int lat;
        bit got;
        lat = exp_lat(key);
        @(negedge clk);
        bif.start       = 1'b1;
        bif.cipher_text = enc(pt, key);
        bif.master_key  = key;
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        chk({tag, "_busy"}, 80'(bif.busy), 80'(1));
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (bif.done) got = 1'b1;
            else begin
                bif.start       = (n == poke_a) || (n == poke_b);
                bif.cipher_text = rand64();
                bif.master_key  = rand80();
            end
        end
        bif.start = 1'b0;
        chk({tag, "_lat"}, 80'(n), 80'(lat));
        chk({tag, "_pt"}, 80'(bif.plain_text), 80'(pt));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 80'(bif.done), 80'(0));
        chk({tag, "_hold"}, 80'(bif.plain_text), 80'(pt));
    endtask

    initial begin
        bif.start       = 1'b0;
        bif.cipher_text = '0;
        bif.master_key  = '0;
        apply_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 80'(bif.busy), 80'(0));
        chk("rst_done", 80'(bif.done), 80'(0));
        chk("rst_pt", 80'(bif.plain_text), 80'(0));
        @(negedge clk);
        rst = 1'b1;

        // All-zero plaintext and key
        do_op(64'h0, 80'h0, 0, 0, "zero");

        // Random loopback
        for (int i = 0; i < 200; i++) do_op(rand64(), rand80(), 0, 0, "loop");

        // Extra start pulses while busy are ignored
        do_op(rand64(), rand80(), 5, 40, "poke");

        // Reset in the middle of an operation
        @(negedge clk);
        bif.start       = 1'b1;
        bif.cipher_text = rand64();
        bif.master_key  = rand80();
        @(posedge clk);
        #1;
        bif.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        apply_reset();
        #1;
        chk("abort_busy", 80'(bif.busy), 80'(0));
        chk("abort_done", 80'(bif.done), 80'(0));
        chk("abort_pt", 80'(bif.plain_text), 80'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("abort_quiet", 80'(bif.done), 80'(0));
        @(negedge clk);
        rst = 1'b1;
        do_op(rand64(), rand80(), 0, 0, "post_rst");

        // start held high: three back-to-back operations
        for (int i = 0; i < 3; i++) begin
            h_pt[i]  = rand64();
            h_key[i] = rand80();
            h_due[i] = exp_lat(h_key[i]) + ((i == 0) ? 0 : h_due[i-1] + 1);
        end
        @(negedge clk);
        bif.start       = 1'b1;
        bif.cipher_text = enc(h_pt[0], h_key[0]);
        bif.master_key  = h_key[0];
        @(posedge clk);
        for (int t = 1; t <= h_due[2] + 5; t++) begin
            @(posedge clk);
            #1;
            if (bif.done) begin
                seen_t.push_back(t);
                seen_pt.push_back(bif.plain_text);
                if (seen_t.size() < 3) begin
                    bif.cipher_text = enc(h_pt[seen_t.size()], h_key[seen_t.size()]);
                    bif.master_key  = h_key[seen_t.size()];
                end else begin
                    bif.start = 1'b0;
                end
            end
        end
        bif.start = 1'b0;
        chk("b2b_count", 80'(seen_t.size()), 80'(3));
        for (int i = 0; i < 3 && i < seen_t.size(); i++) begin
            chk("b2b_time", 80'(seen_t[i]), 80'(h_due[i]));
            chk("b2b_pt", 80'(seen_pt[i]), 80'(h_pt[i]));
        end

        // Same key twice, then a different key
        key_a = rand80();
        pt_a  = rand64();
        do_op(pt_a, key_a, 0, 0, "key_first");
        do_op(rand64(), key_a, 0, 0, "key_repeat");
        do_op(rand64(), rand80(), 0, 0, "key_change");
        do_op(rand64(), key_a, 0, 0, "key_back");
        lat_a = 0;

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
